// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller.
package fetch_pkg;

  localparam int unsigned PcW            = 32;
  localparam int unsigned DefaultIdxW    = 8;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  // A misaligned redirect parks the fetcher in StHalt until reset.
  typedef enum logic {
    StRun  = 1'b0,
    StHalt = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// PC generation and fetch control in front of a synchronous (1-cycle) instruction memory.
// F is the address being read this cycle; if_pc_o tags the word the memory presents now.
module pc_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [PcW-1:0] RESET_PC = DefaultResetPc,
  parameter int unsigned    IDX_W    = DefaultIdxW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [PcW-1:0]   redirect_pc_i,
  output logic [IDX_W-1:0] imem_pc_o,
  output logic [PcW-1:0]   if_pc_o,
  output logic             if_valid_o,
  output logic             misalign_o,
  output logic [15:0]      fetch_cnt_o
);

  fetch_state_e   state_q;
  logic [PcW-1:0] f_q;
  logic [PcW-1:0] if_pc_q;
  logic           if_valid_q;
  logic           misalign_q;
  logic [15:0]    fetch_cnt_q;

  assign if_pc_o     = if_pc_q;
  assign if_valid_o  = if_valid_q;
  assign misalign_o  = misalign_q;
  assign fetch_cnt_o = fetch_cnt_q;

  // Memory address: on a plain stall re-read the held word so the memory output stays put.
  always_comb begin
    imem_pc_o = f_q[IDX_W+1:2];
    if (!rst_n) begin
      imem_pc_o = RESET_PC[IDX_W+1:2];
    end else if (state_q == StHalt) begin
      imem_pc_o = f_q[IDX_W+1:2];
    end else if (stall_i && !redirect_i) begin
      imem_pc_o = if_pc_q[IDX_W+1:2];
    end
  end

  // Fetch FSM with registered outputs; redirect outranks stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StRun;
      f_q         <= RESET_PC;
      if_pc_q     <= RESET_PC;
      if_valid_q  <= 1'b0;
      misalign_q  <= 1'b0;
      fetch_cnt_q <= 16'd0;
    end else begin
      // if_valid_q is always 0 in StHalt, so the counter freezes there.
      if (if_valid_q && !stall_i && (fetch_cnt_q != 16'hFFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
      unique case (state_q)
        StRun: begin
          if (redirect_i) begin
            if_valid_q <= 1'b0;
            if (redirect_pc_i[1:0] != 2'b00) begin
              state_q    <= StHalt;
              misalign_q <= 1'b1;
            end else begin
              f_q <= redirect_pc_i;
            end
          end else if (!stall_i) begin
            if_pc_q    <= f_q;
            f_q        <= f_q + 32'd4;
            if_valid_q <= 1'b1;
          end
        end
        StHalt: begin
          if_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
